// File: rtl/ssd_bin2bcd_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ssd_bin2bcd_feeder: serial double-dabble 32-bit binary to 8-digit BCD,   |
// | hex fallback with dp flags. Optional build macro: SSD_SIGNED_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ssd_bin2bcd_feeder #(
  parameter logic [7:0] OVF_DP_MASK  = 8'h00,
  parameter logic [7:0] NORM_DP_MASK = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] bcd_out,
  output logic [7:0]  dp_out,
  output logic        ovf,
  output logic        done
);

  localparam logic [31:0] C_DEC_LIMIT = 32'd100_000_000;
  localparam logic [5:0]  C_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_bin;
  logic [31:0] r_scratch;
  logic [31:0] r_raw;
  logic [5:0]  r_step;
  logic        r_ovf_pend;
  logic        r_neg;
  logic        r_ready;
  logic [31:0] r_bcd;
  logic [7:0]  r_dp;
  logic        r_ovf;
  logic        r_done;

  logic [31:0] w_adj;
  logic [31:0] w_mag;
  logic        w_neg;

`ifdef SSD_SIGNED_EN
  assign w_neg = in_data[31];
  assign w_mag = w_neg ? (~in_data + 32'd1) : in_data;
`else
  assign w_neg = 1'b0;
  assign w_mag = in_data;
`endif

  // Nibble-local add-3 correction ahead of each shift
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dabble
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                 r_scratch[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bin      <= 32'h0;
      r_scratch  <= 32'h0;
      r_raw      <= 32'h0;
      r_step     <= 6'd0;
      r_ovf_pend <= 1'b0;
      r_neg      <= 1'b0;
      r_ready    <= 1'b1;
      r_bcd      <= 32'h0;
      r_dp       <= 8'hFF;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_ready) begin
            r_bin      <= w_mag;
            r_raw      <= in_data;
            r_scratch  <= 32'h0;
            r_step     <= 6'd0;
            r_ovf_pend <= (w_mag >= C_DEC_LIMIT);
            r_neg      <= w_neg;
            r_ready    <= 1'b0;
            r_state    <= S_CONV;
          end
        end
        S_CONV: begin
          // Bit leaving scratch[31] is dropped; only overflow values reach it
          r_scratch <= {w_adj[30:0], r_bin[31]};
          r_bin     <= {r_bin[30:0], 1'b0};
          r_step    <= r_step + 6'd1;
          if (r_step == C_LAST_STEP) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_ovf_pend) begin
            r_bcd <= r_raw;
            r_dp  <= OVF_DP_MASK;
            r_ovf <= 1'b1;
          end else begin
            r_bcd <= r_scratch;
            r_dp  <= r_neg ? (NORM_DP_MASK & 8'h7F) : NORM_DP_MASK;
            r_ovf <= 1'b0;
          end
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = r_ready;
  assign bcd_out  = r_bcd;
  assign dp_out   = r_dp;
  assign ovf      = r_ovf;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd_bin2bcd_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ssd_bin2bcd_feeder: scoreboard bench with decimal reference model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ssd_bin2bcd_feeder;

  localparam logic [7:0] C_OVF_DP  = 8'h00;
  localparam logic [7:0] C_NORM_DP = 8'hFF;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  dp;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] bcd_out;
  logic [7:0]  dp_out;
  logic        ovf;
  logic        done;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t last;

  ssd_bin2bcd_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_out  (bcd_out),
    .dp_out   (dp_out),
    .ovf      (ovf),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, hex fallback at 10^8
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    logic [31:0] mag;
    logic        neg;
    int unsigned tmp;
    mag = v;
    neg = 1'b0;
`ifdef SSD_SIGNED_EN
    if (v[31]) begin
      neg = 1'b1;
      mag = -v;
    end
`endif
    e.cyc = 0;
    if (mag >= 32'd100000000) begin
      e.bcd = v;
      e.dp  = C_OVF_DP;
      e.ovf = 1'b1;
    end else begin
      tmp = mag;
      e.bcd = 32'h0;
      for (int i = 0; i < 8; i++) begin
        e.bcd[4*i +: 4] = 4'(tmp % 10);
        tmp = tmp / 10;
      end
      e.dp  = neg ? (C_NORM_DP & 8'h7F) : C_NORM_DP;
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following acceptance
  task automatic send(input logic [31:0] v, input bit expect_out);
    exp_t e;
    int   k;
    in_data  = v;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (expect_out) begin
      e = model(v);
      e.cyc = cyc + 34;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 120) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Monitor: compare on done, otherwise outputs must hold the last result
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last.bcd = 32'h0;
      last.dp  = 8'hFF;
      last.ovf = 1'b0;
    end else if (done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: bcd=%h dp=%h ovf=%b, expected no done", bcd_out, dp_out, ovf);
        last.bcd = bcd_out;
        last.dp  = dp_out;
        last.ovf = ovf;
      end else begin
        e = q.pop_front();
        chk("bcd_out", bcd_out, e.bcd);
        chk("dp_out", {24'h0, dp_out}, {24'h0, e.dp});
        chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
        chk("latency_cycle", cyc, e.cyc);
        last = e;
      end
    end else begin
      if (bcd_out !== last.bcd || dp_out !== last.dp || ovf !== last.ovf) begin
        chk("hold_bcd", bcd_out, last.bcd);
        chk("hold_dp", {24'h0, dp_out}, {24'h0, last.dp});
        chk("hold_ovf", {31'h0, ovf}, {31'h0, last.ovf});
      end
    end
  end

  initial begin
    logic [31:0] bnd [6];
    logic [31:0] v;
    bnd[0] = 32'd99999999;
    bnd[1] = 32'd100000000;
    bnd[2] = 32'd0;
    bnd[3] = 32'd1;
    bnd[4] = 32'hFFFFFFFF;
    bnd[5] = 32'd10;

    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd_out, 32'h0);
    chk("rst_dp", {24'h0, dp_out}, 32'hFF);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    send(32'd12345678, 1'b1);
    chk("busy_ready", {31'h0, in_ready}, 32'h0);
    drain();

    send(32'd99999999, 1'b1);
    send(32'd100000000, 1'b1);
    drain();

    send(32'd0, 1'b1);
    send(32'd5, 1'b1);
    drain();

    send(32'd87654321, 1'b0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_bcd", bcd_out, 32'h0);
    chk("midrst_dp", {24'h0, dp_out}, 32'hFF);
    chk("midrst_ovf", {31'h0, ovf}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    send(32'd42, 1'b1);
    send(32'h80000000, 1'b1);
    send(-32'sd42, 1'b1);
    drain();

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = bnd[$urandom_range(0, 5)];
        default: v = $urandom_range(0, 999);
      endcase
      send(v, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    repeat (40) @(negedge clk);
    chk("final_queue", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ssd_bin2bcd_feeder.md
Name: ssd_bin2bcd_feeder

Overview:
Sequential binary-to-BCD converter that sits directly upstream of the eight-digit seven-segment display driver. It accepts a 32-bit binary value over a valid/ready handshake and converts it with a serial shift-add-3 (double-dabble) algorithm. It holds a packed 8-digit BCD word plus a per-digit decimal-point mask, which drive the display driver's digit-nibble and dp-select inputs. Values that do not fit in 8 decimal digits fall back to raw hex display, flagged by decimal points.

Parameters:
OVF_DP_MASK, 8'h00, dp_out value in hex-fallback mode; active-low per digit, default lights all 8 points.
NORM_DP_MASK, 8'hFF, dp_out value for a normal decimal result; default lights no points.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_data  in  32  binary value to display (unsigned; two's complement under the optional feature)
in_valid  in  1  in_data is valid
in_ready  out  1  block is idle and can accept a value
bcd_out  out  32  packed BCD; digit i occupies bits [4i+3:4i], digit 0 is the rightmost; feeds the display nibble input
dp_out  out  8  active-low decimal-point mask; bit i low lights the point on digit i; feeds the display dp-select input
ovf  out  1  high while bcd_out holds the raw-hex fallback
done  out  1  one-cycle pulse when bcd_out, dp_out and ovf have just been updated

Behaviour:
- Reset (asynchronous, any state):
  - state <= IDLE.
  - bcd_out = 32'h0, dp_out = 8'hFF, ovf = 0, done = 0, in_ready = 1.
  - Any conversion in flight is discarded; outputs are not partially updated.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready (acceptance edge E0), capture in_data into a 32-bit binary shift register.
  - Clear a 32-bit BCD scratch register and a 6-bit step counter.
  - Register the overflow decision: ovf_pending = (value >= 100_000_000).
  - Go to CONV.
- CONV:
  - in_ready = 0; in_valid is ignored.
  - Each edge E1..E32 performs one step. First, every scratch nibble >= 5 gets +3 (nibble-local, no carry between nibbles). Then {scratch, bin} shifts left by 1.
  - The bit shifted out of scratch[31] is discarded. This is safe because overflowing values bypass the result.
  - The counter increments each step. At E32 (counter == 31), go to DONE.
- DONE (edge E33):
  - If ovf_pending: bcd_out <= original captured value, dp_out <= OVF_DP_MASK, ovf <= 1.
  - Else: bcd_out <= scratch, dp_out <= NORM_DP_MASK, ovf <= 0.
  - done is registered high for exactly the cycle after E33.
  - Return to IDLE; in_ready is high in the cycle after E33.
- Latency: fixed at 33 edges from acceptance to output update, for both normal and overflow values.
- Throughput: one conversion per 34 cycles. A new value may be accepted on the edge immediately after E33.
- Outputs are stable between updates, so the display driver never sees a partially converted value.
- Boundaries:
  - 99_999_999 gives a normal result.
  - 100_000_000 and above trigger the fallback.
  - 0 gives 32'h00000000 with no fallback.

Optional Feature:
SSD_SIGNED_EN
- Defined:
  - in_data is two's complement.
  - At acceptance, sign = in_data[31] and the magnitude (negated when negative) is converted.
  - The overflow test is magnitude >= 100_000_000; 32'h80000000 overflows.
  - For a non-overflow negative result, dp_out = NORM_DP_MASK with bit 7 forced low, so the leftmost point acts as a minus sign.
  - Overflow fallback shows the raw in_data bits; the sign does not alter OVF_DP_MASK.
- Undefined: in_data is unsigned and no sign logic exists.
- Timing: identical in both builds.

Test Plan:
- Reset, then in_data=32'd12345678 with in_valid for one cycle -> in_ready low for 33 cycles; then bcd_out=32'h12345678, dp_out=8'hFF, ovf=0, one-cycle done 33 edges after acceptance.
- in_data=32'd99999999 -> bcd_out=32'h99999999, ovf=0. Then in_data=32'd100000000 -> bcd_out=32'h05F5E100, dp_out=8'h00, ovf=1.
- in_data=0, then in_data=32'd5 held valid through the busy period -> 32'd5 is accepted only once in_ready returns; bcd_out goes 32'h00000000, then 32'h00000005; exactly two done pulses.
- Assert rst at step 15 of converting 32'd87654321 -> outputs immediately 32'h0 / 8'hFF / ovf=0, no done pulse. After release, 32'd42 converts to 32'h00000042.
- Back-to-back: valid asserted on the cycle after done -> accepted on that edge; inter-result spacing is exactly 34 cycles.
- With SSD_SIGNED_EN: in_data=-42 -> bcd_out=32'h00000042, dp_out=8'h7F. in_data=32'h80000000 -> ovf=1, bcd_out=32'h80000000.
